lsu_writeback: RTL and testbench
================================

// Module: lsu_writeback
// PURPOSE
//  Memory/writeback stage that consumes the execute stage's alu_result, rd2 and rd.
//  Loads/stores use alu_result as byte address on a req/gnt/rvalid data bus; loads sign/zero-extend per funct3.
//  ALU ops pass alu_result straight through; every retiring op drives one writeback beat into regfile.
//  Holds one op at a time; in_ready throttles execute.
// PARAMETERS
//  XLEN         32  datapath/address width
//  MEM_TIMEOUT  16  max cycles in REQ+WAIT before abort; 0 disables counter
// PORTS
//  clk         in   1     clock, rising edge
//  rst_n       in   1     reset, asynchronous, active-low
//  in_valid    in   1     execute presents op
//  in_ready    out  1     stage can accept op (high only in IDLE)
//  alu_result  in   XLEN  ALU result / effective address
//  store_data  in   XLEN  rd2 from execute
//  rd          in   5     destination register
//  funct3      in   3     access size/sign
//  is_load     in   1     op is load
//  is_store    in   1     op is store (is_load&&is_store: treated as load)
//  reg_write   in   1     ALU op writes rd
//  mem_req     out  1     bus request, held until mem_gnt
//  mem_we      out  1     1=store
//  mem_addr    out  XLEN  word-aligned address ({addr[XLEN-1:2],2'b00})
//  mem_wdata   out  XLEN  store data, byte/half replicated across lanes
//  mem_wstrb   out  4     byte enables
//  mem_gnt     in   1     bus accepted request
//  mem_rvalid  in   1     read data valid
//  mem_rdata   in   XLEN  read data
//  wb_we       out  1     regfile write strobe, 1-cycle pulse
//  wb_rd       out  5     write address
//  wb_data     out  XLEN  write data
//  err         out  1     1-cycle pulse: timeout, misalign (if enabled), illegal funct3
// BEHAVIOUR
//  Reset: state=IDLE; in_ready=1; mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb, wb_we, wb_rd, wb_data, err=0.
//  FSM: IDLE -> REQ on accepted load/store; IDLE -> WB on accepted ALU op with reg_write; IDLE otherwise.
//   REQ: mem_req=1, outputs stable. On gnt: store -> IDLE; load -> WAIT.
//   REQ, load, gnt&&rvalid same cycle -> WB directly, rdata captured.
//   WAIT: on mem_rvalid capture rdata -> WB. rvalid outside WAIT/REQ-load ignored.
//   WB: wb_we=1 for exactly one cycle unless rd==0 (wb_we=0, still one cycle) -> IDLE.
//  Latency: ALU op wb_we 1 cycle after accept; load 1 cycle after rvalid; store retires on gnt.
//  Back-to-back: in_ready returns 1 the cycle after WB/store-gnt; no same-cycle accept on exit.
//  Inputs registered at accept; later input changes have no effect.
//  Load extract by addr[1:0]: LB 000 sext byte; LH 001 sext half; LW 010; LBU 100 zext; LHU 101 zext.
//  Store wstrb: SB 0001<<a[1:0]; SH 0011<<{a[1],1'b0}; SW 1111. Other funct3 -> err pulse, no bus op.
//  Halfword uses addr[1]; misaligned half/word with macro off: low bits ignored (aligned access).
//  Timeout: counter clears on accept, counts REQ+WAIT cycles; reaching MEM_TIMEOUT -> err, mem_req=0,
//   no writeback, IDLE. MEM_TIMEOUT=0: wait forever.
//  rst_n low mid-op: immediate abort to reset values; pending bus response ignored.
// CONFIGURATION
//  LSU_MISALIGN_TRAP_EN defined: LH/LHU/SH with addr[0]=1 or LW/SW with addr[1:0]!=0 -> err pulse
//   the cycle after accept, no mem_req, no writeback, IDLE.
//  Undefined: no misalign check; access proceeds at aligned address as above.
// TESTING
//  ALU op alu_result=0x1234_5678, rd=5, reg_write=1 -> next cycle wb_we=1, wb_rd=5, wb_data=0x1234_5678.
//  LB addr=0x103, rdata=0x80FF_0000 after 3-cycle gnt delay -> wb_data=0xFFFF_FF80; LBU -> 0x0000_0080.
//  SH addr=0x202, store_data=0xABCD -> mem_addr=0x200, wstrb=1100, wdata=0xABCD_ABCD, mem_we=1; no wb_we.
//  Load, gnt but no rvalid for MEM_TIMEOUT=16 cycles -> err pulse, wb_we never asserted, in_ready=1.
//  LW addr=0x6 -> macro on: err, no mem_req; off: mem_addr=0x4, normal writeback.
//  rst_n low while in WAIT, then rvalid -> all outputs 0, no wb_we; LW rd=0 -> wb_we stays 0.

Source files
------------

// File: rtl/lsu_writeback.sv
// Memory/writeback stage: one op in flight, req/gnt/rvalid data bus, single-beat regfile writeback.
// Optional misaligned-access trap is enabled by defining LSU_MISALIGN_TRAP_EN.
module lsu_writeback #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] store_data,
  input  logic [4:0]      rd,
  input  logic [2:0]      funct3,
  input  logic            is_load,
  input  logic            is_store,
  input  logic            reg_write,
  output logic            mem_req,
  output logic            mem_we,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic            mem_gnt,
  input  logic            mem_rvalid,
  input  logic [XLEN-1:0] mem_rdata,
  output logic            wb_we,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            err
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StWb} state_e;

  state_e          state_q, state_d;
  logic            load_q;
  logic [XLEN-1:0] addr_q;
  logic [XLEN-1:0] wdata_q;
  logic [3:0]      strb_q;
  logic [2:0]      funct3_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] data_q;
  logic [31:0]     cnt_q;
  logic            err_q, err_d;

  logic            accept;
  logic            is_mem;
  logic            f3_legal;
  logic            misalign;
  logic            mem_ok;
  logic            timeout;
  logic            capture;
  logic [XLEN-1:0] wdata_rep;
  logic [3:0]      strb_acc;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] rdata_ext;

  assign in_ready = (state_q == StIdle);
  assign accept   = in_valid && in_ready;
  assign is_mem   = is_load || is_store;

  // Loads win when both is_load and is_store are set.
  always_comb begin
    f3_legal = 1'b0;
    if (is_load) begin
      f3_legal = funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end else begin
      f3_legal = funct3 inside {3'b000, 3'b001, 3'b010};
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((funct3[1:0] == 2'b01) && alu_result[0]) ||
                    ((funct3[1:0] == 2'b10) && (alu_result[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  assign mem_ok  = is_mem && f3_legal && !misalign;
  // Comparing with >= lets a grant that lands on the last allowed cycle still time out in WAIT.
  assign timeout = (MEM_TIMEOUT != 0) && (cnt_q >= MEM_TIMEOUT - 1);

  always_comb begin
    wdata_rep = store_data;
    strb_acc  = 4'b1111;
    unique case (funct3[1:0])
      2'b00: begin
        wdata_rep = {(XLEN/8){store_data[7:0]}};
        strb_acc  = 4'b0001 << alu_result[1:0];
      end
      2'b01: begin
        wdata_rep = {(XLEN/16){store_data[15:0]}};
        strb_acc  = 4'b0011 << {alu_result[1], 1'b0};
      end
      default: begin
        wdata_rep = store_data;
        strb_acc  = 4'b1111;
      end
    endcase
  end

  always_comb begin
    byte_sel  = mem_rdata[{addr_q[1:0], 3'b000} +: 8];
    half_sel  = mem_rdata[{addr_q[1], 4'b0000} +: 16];
    rdata_ext = mem_rdata;
    case (funct3_q)
      3'b000:  rdata_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'b001:  rdata_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'b100:  rdata_ext = {{(XLEN-8){1'b0}}, byte_sel};
      3'b101:  rdata_ext = {{(XLEN-16){1'b0}}, half_sel};
      default: rdata_ext = mem_rdata;
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    capture = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (is_mem) begin
            if (mem_ok) state_d = StReq;
            else        err_d   = 1'b1;
          end else if (reg_write) begin
            state_d = StWb;
          end
        end
      end
      StReq: begin
        if (mem_gnt) begin
          if (!load_q) begin
            state_d = StIdle;
          end else if (mem_rvalid) begin
            state_d = StWb;
            capture = 1'b1;
          end else begin
            state_d = StWait;
          end
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StWait: begin
        if (mem_rvalid) begin
          state_d = StWb;
          capture = 1'b1;
        end else if (timeout) begin
          state_d = StIdle;
          err_d   = 1'b1;
        end
      end
      StWb:    state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load_q   <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      strb_q   <= '0;
      funct3_q <= '0;
      rd_q     <= '0;
      data_q   <= '0;
      cnt_q    <= '0;
    end else begin
      if (accept) begin
        load_q   <= is_load;
        addr_q   <= alu_result;
        wdata_q  <= wdata_rep;
        strb_q   <= strb_acc;
        funct3_q <= funct3;
        rd_q     <= rd;
        data_q   <= alu_result;
        cnt_q    <= '0;
      end else if ((state_q == StReq) || (state_q == StWait)) begin
        cnt_q <= cnt_q + 32'd1;
      end
      if (capture) data_q <= rdata_ext;
    end
  end

  assign mem_req   = (state_q == StReq);
  assign mem_we    = mem_req && !load_q;
  assign mem_addr  = mem_req ? {addr_q[XLEN-1:2], 2'b00} : '0;
  assign mem_wdata = mem_we ? wdata_q : '0;
  assign mem_wstrb = mem_we ? strb_q : '0;
  assign wb_we     = (state_q == StWb) && (rd_q != 5'd0);
  assign wb_rd     = (state_q == StWb) ? rd_q : '0;
  assign wb_data   = (state_q == StWb) ? data_q : '0;
  assign err       = err_q;

endmodule

// File: tb/tb_lsu_writeback.sv
// Directed bench for lsu_writeback: expected writebacks, bus requests and errors go into
// a scoreboard that a negedge monitor drains as the DUT presents them.
module tb_lsu_writeback;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] alu_result = '0;
  logic [31:0] store_data = '0;
  logic [4:0]  rd = '0;
  logic [2:0]  funct3 = '0;
  logic        is_load = 1'b0;
  logic        is_store = 1'b0;
  logic        reg_write = 1'b0;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        wb_we;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err;

  always #5 clk = ~clk;

  lsu_writeback #(.XLEN(32), .MEM_TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .store_data(store_data), .rd(rd), .funct3(funct3),
    .is_load(is_load), .is_store(is_store), .reg_write(reg_write),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .wb_we(wb_we), .wb_rd(wb_rd), .wb_data(wb_data), .err(err)
  );

  typedef struct packed {logic [4:0] rd; logic [31:0] data;} wb_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} bus_t;

  wb_t  exp_wb[$];
  bus_t exp_bus[$];
  int   exp_err = 0;
  int   err_seen = 0;
  int   vectors = 0;
  int   miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_wb(input logic [4:0] r, input logic [31:0] d);
    wb_t e;
    e.rd = r;
    e.data = d;
    exp_wb.push_back(e);
  endtask

  task automatic push_bus(input logic we, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] ws);
    bus_t e;
    e.we = we;
    e.addr = a;
    e.wdata = wd;
    e.wstrb = ws;
    exp_bus.push_back(e);
  endtask

  // Monitor: drains the scoreboard whenever the DUT presents an event.
  always @(negedge clk) begin
    wb_t  w;
    bus_t b;
    if (rst_n) begin
      if (wb_we) begin
        if (exp_wb.size() == 0) begin
          check("unexpected wb_we", 32'(wb_we), 32'd0);
        end else begin
          w = exp_wb.pop_front();
          check("wb_rd", 32'(wb_rd), 32'(w.rd));
          check("wb_data", wb_data, w.data);
        end
      end
      if (mem_req && mem_gnt) begin
        if (exp_bus.size() == 0) begin
          check("unexpected bus request", 32'(mem_req), 32'd0);
        end else begin
          b = exp_bus.pop_front();
          check("mem_we", 32'(mem_we), 32'(b.we));
          check("mem_addr", mem_addr, b.addr);
          if (b.we) begin
            check("mem_wdata", mem_wdata, b.wdata);
            check("mem_wstrb", 32'(mem_wstrb), 32'(b.wstrb));
          end
        end
      end
      if (err) err_seen++;
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Presents one op for one cycle, then scrambles the inputs.
  task automatic issue(input logic ld, input logic st, input logic rw, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] sd, input logic [4:0] r);
    int guard = 0;
    while (!in_ready && guard < 40) begin
      cyc(1);
      guard++;
    end
    check("in_ready before issue", 32'(in_ready), 32'd1);
    in_valid = 1'b1; is_load = ld; is_store = st; reg_write = rw;
    funct3 = f3; alu_result = a; store_data = sd; rd = r;
    cyc(1);
    in_valid = 1'b0; is_load = 1'b1; is_store = 1'b1; reg_write = 1'b1;
    funct3 = 3'($urandom); alu_result = $urandom; store_data = $urandom; rd = 5'($urandom);
  endtask

  task automatic grant(input int dly, input logic rv, input logic [31:0] d);
    cyc(dly);
    mem_gnt = 1'b1; mem_rvalid = rv; mem_rdata = d;
    cyc(1);
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
  endtask

  task automatic rvalid_pulse(input int dly, input logic [31:0] d);
    cyc(dly);
    mem_rvalid = 1'b1; mem_rdata = d;
    cyc(1);
    mem_rvalid = 1'b0; mem_rdata = $urandom;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    check({tag, " mem_req"}, 32'(mem_req), 32'd0);
    check({tag, " mem_we"}, 32'(mem_we), 32'd0);
    check({tag, " mem_addr"}, mem_addr, 32'd0);
    check({tag, " mem_wdata"}, mem_wdata, 32'd0);
    check({tag, " mem_wstrb"}, 32'(mem_wstrb), 32'd0);
    check({tag, " wb_we"}, 32'(wb_we), 32'd0);
    check({tag, " wb_rd"}, 32'(wb_rd), 32'd0);
    check({tag, " wb_data"}, wb_data, 32'd0);
    check({tag, " err"}, 32'(err), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    cyc(3);
    check_idle_outputs("reset");
    rst_n = 1'b1;
    cyc(1);

    // ALU op: writeback one cycle after accept, ready again the cycle after.
    push_wb(5'd5, 32'h1234_5678);
    issue(1'b0, 1'b0, 1'b1, 3'b000, 32'h1234_5678, 32'h0, 5'd5);
    check("alu wb latency", 32'(wb_we), 32'd1);
    check("in_ready low in WB", 32'(in_ready), 32'd0);
    cyc(1);
    check("in_ready after WB", 32'(in_ready), 32'd1);

    // ALU op without reg_write: nothing retires.
    issue(1'b0, 1'b0, 1'b0, 3'b000, 32'hFFFF_0000, 32'h0, 5'd6);
    check("no-write alu in_ready", 32'(in_ready), 32'd1);

    // LB 0x103, 3-cycle grant delay, rvalid the cycle after grant.
    push_bus(1'b0, 32'h100, 32'h0, 4'h0);
    push_wb(5'd7, 32'hFFFF_FF80);
    issue(1'b1, 1'b0, 1'b0, 3'b000, 32'h103, 32'h0, 5'd7);
    check("mem_req in REQ", 32'(mem_req), 32'd1);
    check("in_ready low in REQ", 32'(in_ready), 32'd0);
    grant(3, 1'b0, 32'h0);
    rvalid_pulse(0, 32'h80FF_0000);
    check("load wb latency", 32'(wb_we), 32'd1);
    cyc(1);

    // LBU, grant and rvalid together.
    push_bus(1'b0, 32'h100, 32'h0, 4'h0);
    push_wb(5'd8, 32'h0000_0080);
    issue(1'b1, 1'b0, 1'b0, 3'b100, 32'h103, 32'h0, 5'd8);
    grant(3, 1'b1, 32'h80FF_0000);
    cyc(1);

    // LH upper half, LHU lower half, LW.
    push_bus(1'b0, 32'h100, 32'h0, 4'h0);
    push_wb(5'd12, 32'hFFFF_8001);
    issue(1'b1, 1'b0, 1'b0, 3'b001, 32'h102, 32'h0, 5'd12);
    grant(0, 1'b0, 32'h0);
    rvalid_pulse(2, 32'h8001_7FFF);
    cyc(1);
    push_bus(1'b0, 32'h100, 32'h0, 4'h0);
    push_wb(5'd13, 32'h0000_F00F);
    issue(1'b1, 1'b0, 1'b0, 3'b101, 32'h100, 32'h0, 5'd13);
    grant(1, 1'b1, 32'h8001_F00F);
    cyc(1);
    push_bus(1'b0, 32'h104, 32'h0, 4'h0);
    push_wb(5'd14, 32'hCAFE_BABE);
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h104, 32'h0, 5'd14);
    grant(0, 1'b1, 32'hCAFE_BABE);
    cyc(1);

    // Stores: retire on grant, no writeback.
    push_bus(1'b1, 32'h200, 32'hABCD_ABCD, 4'b1100);
    issue(1'b0, 1'b1, 1'b0, 3'b001, 32'h202, 32'h0000_ABCD, 5'd3);
    grant(1, 1'b0, 32'h0);
    check("store in_ready after gnt", 32'(in_ready), 32'd1);
    push_bus(1'b1, 32'h100, 32'hEFEF_EFEF, 4'b0010);
    issue(1'b0, 1'b1, 1'b0, 3'b000, 32'h101, 32'h1234_56EF, 5'd3);
    grant(0, 1'b0, 32'h0);
    push_bus(1'b1, 32'h300, 32'hDEAD_BEEF, 4'b1111);
    issue(1'b0, 1'b1, 1'b0, 3'b010, 32'h300, 32'hDEAD_BEEF, 5'd3);
    grant(2, 1'b0, 32'h0);

    // Illegal funct3: error pulse the cycle after accept, no bus op.
    exp_err++;
    issue(1'b0, 1'b1, 1'b0, 3'b011, 32'h400, 32'h0, 5'd1);
    check("illegal store err", 32'(err), 32'd1);
    check("illegal store mem_req", 32'(mem_req), 32'd0);
    cyc(1);
    check("illegal err one cycle", 32'(err), 32'd0);
    exp_err++;
    issue(1'b1, 1'b0, 1'b0, 3'b110, 32'h400, 32'h0, 5'd1);
    check("illegal load err", 32'(err), 32'd1);
    cyc(1);

    // LW to 0x6.
`ifdef LSU_MISALIGN_TRAP_EN
    exp_err++;
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h6, 32'h0, 5'd9);
    check("misalign err", 32'(err), 32'd1);
    check("misalign mem_req", 32'(mem_req), 32'd0);
    cyc(1);
`else
    push_bus(1'b0, 32'h4, 32'h0, 4'h0);
    push_wb(5'd9, 32'h0BAD_F00D);
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h6, 32'h0, 5'd9);
    check("misalign no err", 32'(err), 32'd0);
    grant(0, 1'b1, 32'h0BAD_F00D);
    cyc(1);
`endif

    // Timeout: granted load never gets rvalid; 16 cycles in REQ+WAIT.
    push_bus(1'b0, 32'h400, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h400, 32'h0, 5'd10);
    grant(0, 1'b0, 32'h0);
    cyc(14);
    check("timeout not yet", 32'(err), 32'd0);
    check("timeout still busy", 32'(in_ready), 32'd0);
    cyc(1);
    exp_err++;
    check("timeout err", 32'(err), 32'd1);
    check("timeout in_ready", 32'(in_ready), 32'd1);
    rvalid_pulse(0, 32'h1111_1111);
    cyc(2);

    // Reset while waiting for read data; later rvalid must be ignored.
    push_bus(1'b0, 32'h500, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h500, 32'h0, 5'd11);
    grant(0, 1'b0, 32'h0);
    cyc(2);
    rst_n = 1'b0;
    #1;
    check_idle_outputs("mid-op reset");
    rvalid_pulse(0, 32'h2222_2222);
    rst_n = 1'b1;
    rvalid_pulse(1, 32'h3333_3333);
    check("post-reset wb_we", 32'(wb_we), 32'd0);
    cyc(1);

    // LW to x0: one WB cycle with no write strobe.
    push_bus(1'b0, 32'h600, 32'h0, 4'h0);
    issue(1'b1, 1'b0, 1'b0, 3'b010, 32'h600, 32'h0, 5'd0);
    grant(0, 1'b1, 32'h4444_4444);
    check("rd0 wb_we", 32'(wb_we), 32'd0);
    check("rd0 WB cycle busy", 32'(in_ready), 32'd0);
    cyc(1);
    check("rd0 ready after WB", 32'(in_ready), 32'd1);

    cyc(3);
    check("wb queue drained", 32'(exp_wb.size()), 32'd0);
    check("bus queue drained", 32'(exp_bus.size()), 32'd0);
    check("err pulse count", 32'(err_seen), 32'(exp_err));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
